ac_checker: RTL
===============

Name: ac_checker

Overview:
- Access-control enforcement stage downstream of the secure key/fuse register bank.
- Consumes the per-master access-control words held in that bank (entries 2 and 3: master 0, master 1).
- Checks each bus-master request against the 4-bit permission nibble for the target peripheral, then returns grant or error over a valid/ready handshake.
- Tracks violations per master and locks out a master that exceeds a threshold.

Parameters:
- NrMasters, 2, number of bus masters; one 64-bit AC word each.
- NrPeriph, 16, peripherals covered; nibble p is AC word bits [4p+3:4p].
- LockThresh, 4, violation count at which a master locks; range 1..255.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- ac_word_i  in  NrMasters x 64  low 64 bits of the secure-register AC entries; entry 2 maps to master 0, entry 3 to master 1.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_master_i  in  $clog2(NrMasters)  requesting master.
- req_periph_i  in  $clog2(NrPeriph)  target peripheral.
- req_type_i  in  2  0=read, 1=write, 2=exec, 3=illegal.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response ready.
- resp_grant_o  out  1  access permitted.
- resp_err_o  out  1  access denied; always equals !resp_grant_o when resp_valid_o=1.
- lock_o  out  NrMasters  master locked out (sticky).
- viol_cnt_o  out  NrMasters x 8  saturating violation counters.

Behaviour:
- Permission nibble bits: bit0=R, bit1=W, bit2=X, bit3=reserved (ignored).
- Grant condition: nibble bit[req_type] = 1, the master is not locked, and req_type != 3.
- Sampling: ac_word_i is read live in the acceptance cycle; there is no snapshot.
- Handshake:
  - A request is accepted when req_valid_i && req_ready_o.
  - req_ready_o = !resp_valid_o || resp_ready_i. This is a single-entry output register with full throughput.
  - Latency: response appears the cycle after acceptance.
  - resp_* holds stable while resp_valid_o && !resp_ready_i.
  - If accept and resp pop occur in the same cycle, the new response replaces the old one with no bubble.
- Per-master FSM, states OPEN and LOCKED:
  - OPEN→LOCKED when the counter reaches LockThresh; the transition takes effect in the same cycle the counter is updated.
  - LOCKED→OPEN only on reset.
  - While LOCKED, every request from that master is denied. Denials while locked still increment the counter.
- Counter: +1 per denied request at acceptance; saturates at 255 and never wraps.
- Multiple masters: counters and FSMs are independent. Only one request is accepted per cycle, so there is no simultaneous-update conflict.
- Bounds: req_periph_i ≥ NrPeriph is denied and counts as a violation.
- Reset values (asynchronous, mid-transaction included): resp_valid_o=0, resp_grant_o=0, resp_err_o=0, lock_o=0, viol_cnt_o=0, all FSMs OPEN. Any pending response is dropped.
- ac_word_i changing while a response is pending does not alter that response.

Optional Feature:
- Macro: AC_AUDIT_EN.
- With AC_AUDIT_EN defined:
  - Adds outputs audit_valid_o (1) and audit_o (master, periph, type, packed).
  - These capture the first denied request after reset and stay sticky until reset.
  - Later violations do not overwrite the capture.
- Without it: the ports and capture registers are absent; all other behaviour is identical.

Decomposition:
- Package ac_pkg contains:
  - req_type_e (READ, WRITE, EXEC, ILLEGAL).
  - Permission bit index constants PERM_R/W/X.
  - ac_resp_t struct {grant, err}.
  - Default LockThresh and counter width (8).
- Sub-module ac_viol_tracker: one instance per master; holds the counter and the OPEN/LOCKED FSM; inputs viol_pulse, outputs lock and count.

Test Plan:
- Master 0, ac_word=0x0000fff8_ff6ff00f:
  - read p0 → grant.
  - read p1 → err.
  - read p5 (nibble 6) → err.
  - write p5 → grant.
  - Each response arrives 1 cycle after accept.
- Master 0 reads p8 (nibble 8, reserved bit only) → err; viol_cnt_o[0] increments by 1.
- Master 1, ac_word=0x0000f8f8_ff6fe00f, four denied reads of p1 (LockThresh=4):
  - lock_o[1]=1 after the 4th.
  - A following write p0 (nibble f) → err.
  - Master 0 is unaffected.
- resp_ready_i held 0 for 5 cycles: req_ready_o=0, resp fields stable. Release with a new request pending → back-to-back responses, no bubble.
- Assert rst_ni mid-stall with resp_valid_o=1 and lock_o[1]=1 → all outputs 0 immediately (asynchronous); after release, master 1 read p0 → grant.
- AC_AUDIT_EN, two violations (m0/p1/read, then m1/p2/write) → audit_o holds m0/p1/read, audit_valid_o=1.

Source files
------------

// File: rtl/ac_pkg.sv
// ac_pkg: shared types and constants for the access-control checker
package ac_pkg;
    typedef enum logic [1:0] {READ, WRITE, EXEC, ILLEGAL} req_type_e;
    localparam int PERM_R = 0;
    localparam int PERM_W = 1;
    localparam int PERM_X = 2;
    localparam int LOCK_THRESH_DEF = 4;
    localparam int CNT_W = 8;
    typedef struct packed {
        logic grant;
        logic err;
    } ac_resp_t;
endpackage

// File: rtl/ac_if.sv
// ac_if: request/response handshake between a bus master and the access-control checker
interface ac_if
    import ac_pkg::*;
#(
    parameter int NrMasters = 2,
    parameter int NrPeriph  = 16
);
    localparam int MW = NrMasters > 1 ? $clog2(NrMasters) : 1;
    localparam int PW = $clog2(NrPeriph);
    logic          req_valid_i;
    logic          req_ready_o;
    logic [MW-1:0] req_master_i;
    logic [PW-1:0] req_periph_i;
    req_type_e     req_type_i;
    logic          resp_valid_o;
    logic          resp_ready_i;
    logic          resp_grant_o;
    logic          resp_err_o;
    modport slave (
        input  req_valid_i, req_master_i, req_periph_i, req_type_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_grant_o, resp_err_o
    );
    modport master (
        output req_valid_i, req_master_i, req_periph_i, req_type_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_grant_o, resp_err_o
    );
endinterface

// File: rtl/ac_viol_tracker.sv
// ac_viol_tracker: per-master saturating violation counter with sticky OPEN/LOCKED state
module ac_viol_tracker
    import ac_pkg::*;
#(
    parameter int LockThresh = LOCK_THRESH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             viol_pulse,
    output logic             lock,
    output logic [CNT_W-1:0] count
);
    localparam logic [0:0] OPEN   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;
    logic [0:0]       state;
    logic [CNT_W-1:0] cnt_n;
    assign cnt_n = &count ? count : count + 1'b1;
    assign lock  = state == LOCKED;
    // lock is decided from the incremented value so it lands with the count update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
            state <= OPEN;
        end else if (viol_pulse) begin
            count <= cnt_n;
            state <= cnt_n >= CNT_W'(LockThresh) ? LOCKED : state;
        end
    end
endmodule

// File: rtl/ac_checker.sv
// ac_checker: per-master peripheral permission check with violation lockout
// optional AC_AUDIT_EN adds a sticky capture of the first denied request
module ac_checker
    import ac_pkg::*;
#(
    parameter int NrMasters  = 2,
    parameter int NrPeriph   = 16,
    parameter int LockThresh = LOCK_THRESH_DEF
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NrMasters-1:0][63:0]          ac_word_i,
    ac_if.slave                                 bus,
    output logic [NrMasters-1:0]                lock_o,
    output logic [NrMasters-1:0][CNT_W-1:0]     viol_cnt_o
`ifdef AC_AUDIT_EN
    ,
    output logic                                audit_valid_o,
    output logic [(NrMasters > 1 ? $clog2(NrMasters) : 1)+$clog2(NrPeriph)+1:0] audit_o
`endif
);
    localparam int PW = $clog2(NrPeriph);
    localparam logic [2**PW-1:0] PERIPH_OK = {(2**PW){1'b1}} >> (2**PW - NrPeriph);
    logic                 accept;
    logic                 grant_d;
    logic                 deny;
    logic [3:0]           nib;
    logic [NrMasters-1:0] viol;
    ac_resp_t             resp_q;
    logic                 valid_q;
    assign bus.req_ready_o  = !valid_q || bus.resp_ready_i;
    assign bus.resp_valid_o = valid_q;
    assign bus.resp_grant_o = resp_q.grant;
    assign bus.resp_err_o   = resp_q.err;
    assign accept  = bus.req_valid_i && bus.req_ready_o;
    assign nib     = ac_word_i[bus.req_master_i][{bus.req_periph_i, 2'b00} +: 4];
    assign grant_d = PERIPH_OK[bus.req_periph_i] && !lock_o[bus.req_master_i] &&
                     bus.req_type_i != ILLEGAL && nib[bus.req_type_i];
    assign deny    = accept && !grant_d;
    assign viol    = NrMasters'(deny) << bus.req_master_i;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            resp_q  <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            resp_q  <= '{grant: grant_d, err: !grant_d};
        end else if (bus.resp_ready_i) begin
            valid_q <= 1'b0;
        end
    end
    for (genvar m = 0; m < NrMasters; m++) begin : g_trk
        ac_viol_tracker #(.LockThresh(LockThresh)) u_trk (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .viol_pulse(viol[m]),
            .lock      (lock_o[m]),
            .count     (viol_cnt_o[m])
        );
    end
`ifdef AC_AUDIT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            audit_valid_o <= 1'b0;
            audit_o       <= '0;
        end else if (deny && !audit_valid_o) begin
            audit_valid_o <= 1'b1;
            audit_o       <= {bus.req_master_i, bus.req_periph_i, bus.req_type_i};
        end
    end
`endif
endmodule
